// File: rtl/dsp_post_adder_acc.sv
// Post-adder / accumulator stage of a DSP48A1-style slice.
// Selects X and Z operands from M, D:A:B, C, PCIN and the P feedback, then
// adds or subtracts them with carry-in, producing a 48-bit result and carry.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ce_p                clock enable for P / CARRYOUT registers
//   ce_opmode           clock enable for the opmode register
//   ce_carryin          clock enable for the carry-in register
//   opmode[7:0]         [1:0] X select, [3:2] Z select, [7] subtract
//   m[35:0]             unsigned product from the M stage
//   dab[47:0]           {D[11:0], A[17:0], B[17:0]}
//   c[47:0]             C operand
//   pcin[47:0]          cascade input from the previous slice
//   carryin             carry-in (source-selected upstream)
//   p[47:0]             result
//   carryout            carry / borrow out of the post-adder
//   carryoutf           fabric copy of carryout
//   pcout[47:0]         cascade output, equal to p
module dsp_post_adder_acc #(
  parameter int unsigned PREG       = 1,
  parameter int unsigned OPMODEREG  = 1,
  parameter int unsigned CARRYINREG = 1,
  parameter int unsigned WIDTH_P    = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce_p,
  input  logic               ce_opmode,
  input  logic               ce_carryin,
  input  logic [7:0]         opmode,
  input  logic [35:0]        m,
  input  logic [WIDTH_P-1:0] dab,
  input  logic [WIDTH_P-1:0] c,
  input  logic [WIDTH_P-1:0] pcin,
  input  logic               carryin,
  output logic [WIDTH_P-1:0] p,
  output logic               carryout,
  output logic               carryoutf,
  output logic [WIDTH_P-1:0] pcout
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned SUM_W = WIDTH_P + 1;

  logic [OP_W-1:0]    opmode_r;
  logic               cyi_r;
  logic [OP_W-1:0]    op_eff;
  logic               cin_eff;
  logic [WIDTH_P-1:0] p_r;
  logic               co_r;
  logic [WIDTH_P-1:0] x_mux;
  logic [WIDTH_P-1:0] z_mux;
  logic [SUM_W-1:0]   sum;
  logic               unused_opmode_bits;

  // Optional input pipeline registers for opmode and carry-in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opmode_r <= '0;
      cyi_r    <= 1'b0;
    end else begin
      if (ce_opmode)  opmode_r <= opmode;
      if (ce_carryin) cyi_r    <= carryin;
    end
  end

  assign op_eff  = (OPMODEREG != 0)  ? opmode_r : opmode;
  assign cin_eff = (CARRYINREG != 0) ? cyi_r    : carryin;

  // Bits [6:4] belong to the pre-adder / multiplier stages
  assign unused_opmode_bits = ^op_eff[6:4];

  // Operand muxes and 49-bit add/subtract; bit 48 is carry or borrow
  always_comb begin
    x_mux = '0;
    z_mux = '0;
    sum   = '0;
    case (op_eff[1:0])
      2'b00:   x_mux = '0;
      2'b01:   x_mux = WIDTH_P'(m);
      2'b10:   x_mux = p_r;
      default: x_mux = dab;
    endcase
    case (op_eff[3:2])
      2'b00:   z_mux = '0;
      2'b01:   z_mux = pcin;
      2'b10:   z_mux = p_r;
      default: z_mux = c;
    endcase
    if (op_eff[7]) begin
      sum = SUM_W'(z_mux) - (SUM_W'(x_mux) + SUM_W'(cin_eff));
    end else begin
      sum = SUM_W'(z_mux) + SUM_W'(x_mux) + SUM_W'(cin_eff);
    end
  end

  generate
    if (PREG != 0) begin : gen_preg
      // Result register; also the accumulator feedback source
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_r  <= '0;
          co_r <= 1'b0;
        end else if (ce_p) begin
          p_r  <= sum[WIDTH_P-1:0];
          co_r <= sum[WIDTH_P];
        end
      end
      assign p        = p_r;
      assign carryout = co_r;
    end else begin : gen_nopreg
      // No result register: feedback reads zero, outputs are combinational
      assign p_r      = '0;
      assign co_r     = 1'b0;
      assign p        = sum[WIDTH_P-1:0];
      assign carryout = sum[WIDTH_P];
    end
  endgenerate

  assign pcout     = p;
  assign carryoutf = carryout;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Self-checking bench for dsp_post_adder_acc (default parameters: all regs on).
module tb_dsp_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_p, ce_opmode, ce_carryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] dab, c, pcin;
  logic        carryin;
  logic [47:0] p, pcout;
  logic        carryout, carryoutf;

  int checks = 0;
  int errors = 0;

  dsp_post_adder_acc dut (
    .clk(clk), .rst_n(rst_n), .ce_p(ce_p), .ce_opmode(ce_opmode),
    .ce_carryin(ce_carryin), .opmode(opmode), .m(m), .dab(dab), .c(c),
    .pcin(pcin), .carryin(carryin), .p(p), .carryout(carryout),
    .carryoutf(carryoutf), .pcout(pcout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [35:0] mv;
    logic [47:0] dabv;
    logic [47:0] cv;
    logic [47:0] pcinv;
    logic        cin;
    logic [47:0] exp_p;
    logic        exp_co;
  } vec_t;

  vec_t vecs[6];

  // Reference state: what the slice should hold, kept as plain numbers
  logic [47:0] ref_p;
  logic        ref_co;
  logic [7:0]  ref_op;
  logic        ref_cin;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [47:0] ep, input logic eco);
    check({name, ".p"}, p, ep);
    check({name, ".pcout"}, pcout, ep);
    check({name, ".carryout"}, 48'(carryout), 48'(eco));
    check({name, ".carryoutf"}, 48'(carryoutf), 48'(eco));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next state from the arithmetic rules, evaluated with signed 64-bit math
  task automatic model_edge();
    longint x, z, r;
    if (!rst_n) return;
    case (ref_op[1:0])
      2'b00: x = 0;
      2'b01: x = longint'(m);
      2'b10: x = longint'(ref_p);
      default: x = longint'(dab);
    endcase
    case (ref_op[3:2])
      2'b00: z = 0;
      2'b01: z = longint'(pcin);
      2'b10: z = longint'(ref_p);
      default: z = longint'(c);
    endcase
    r = ref_op[7] ? (z - x - longint'(ref_cin)) : (z + x + longint'(ref_cin));
    if (ce_p) begin
      ref_p  = r[47:0];
      ref_co = ref_op[7] ? (r < 0) : (r >= 64'sh1_0000_0000_0000);
    end
    if (ce_opmode)  ref_op  = opmode;
    if (ce_carryin) ref_cin = carryin;
  endtask

  initial begin
    vecs[0] = '{"muladd", 8'h0D, 36'd100, 48'd0, 48'd1000, 48'd0, 1'b1, 48'd1101, 1'b0};
    vecs[1] = '{"wrap",   8'h0F, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd1, 48'd0, 1'b0, 48'd0, 1'b1};
    vecs[2] = '{"sub",    8'h8F, 36'd0, 48'd3, 48'd10, 48'd0, 1'b1, 48'd6, 1'b0};
    vecs[3] = '{"borrow", 8'h8F, 36'd0, 48'd20, 48'd10, 48'd0, 1'b1, 48'hFFFF_FFFF_FFF5, 1'b1};
    vecs[4] = '{"cascade",8'h04, 36'd0, 48'd0, 48'd0, 48'h1234, 1'b0, 48'h1234, 1'b0};
    vecs[5] = '{"negm",   8'h81, 36'd1, 48'd0, 48'd0, 48'd0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1};

    // Reset held across edges with non-zero operands
    rst_n = 1'b0; ce_p = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1;
    opmode = 8'h0F; m = 36'd77; dab = 48'd5; c = 48'd9; pcin = 48'd3; carryin = 1'b1;
    #1;
    check_all("reset_async", 48'd0, 1'b0);
    tick(); tick(); tick();
    check_all("reset_held", 48'd0, 1'b0);
    rst_n = 1'b1;

    // Directed vectors: one edge loads opmode_r/cyi_r, the next loads P
    for (int i = 0; i < 6; i++) begin
      opmode = vecs[i].op; m = vecs[i].mv; dab = vecs[i].dabv; c = vecs[i].cv;
      pcin = vecs[i].pcinv; carryin = vecs[i].cin;
      tick(); tick();
      check_all(vecs[i].name, vecs[i].exp_p, vecs[i].exp_co);
    end

    // Reset pulse between edges, then restart from cleared opmode_r
    opmode = 8'h0D; m = 36'd100; c = 48'd1000; carryin = 1'b1;
    tick(); tick();
    check_all("pre_pulse", 48'd1101, 1'b0);
    rst_n = 1'b0; #1;
    check_all("reset_pulse", 48'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("first_after_rel", 48'd0, 1'b0);
    tick();
    check_all("second_after_rel", 48'd1101, 1'b0);

    // Accumulate from P=0
    rst_n = 1'b0; #1; rst_n = 1'b1;
    opmode = 8'h09; m = 36'd5; carryin = 1'b0; ce_p = 1'b0;
    tick();
    ce_p = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_all($sformatf("acc%0d", k), 48'(5 * k), 1'b0);
    end
    ce_p = 1'b0; m = 36'd7;
    tick();
    check_all("acc_hold", 48'd20, 1'b0);

    // Opmode changes on the same edge as a P update: old opmode wins
    ce_p = 1'b1; m = 36'd5; opmode = 8'h04; pcin = 48'h1234;
    tick();
    check_all("op_old", 48'd25, 1'b0);
    tick();
    check_all("op_new", 48'h1234, 1'b0);

    // Randomized run against the reference model
    rst_n = 1'b0; #1; rst_n = 1'b1;
    ref_p = '0; ref_co = 1'b0; ref_op = '0; ref_cin = 1'b0;
    for (int it = 0; it < 400; it++) begin
      opmode     = 8'($urandom);
      m          = 36'({$urandom(), $urandom()});
      c          = 48'({$urandom(), $urandom()});
      pcin       = 48'({$urandom(), $urandom()});
      case ($urandom_range(0, 3))
        0: dab = 48'hFFFF_FFFF_FFFF;
        1: dab = 48'd0;
        default: dab = 48'({$urandom(), $urandom()});
      endcase
      carryin    = 1'($urandom);
      ce_p       = ($urandom_range(0, 7) != 0);
      ce_opmode  = ($urandom_range(0, 3) != 0);
      ce_carryin = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0; #1;
        ref_p = '0; ref_co = 1'b0; ref_op = '0; ref_cin = 1'b0;
        check_all("rnd_reset", ref_p, ref_co);
      end else begin
        rst_n = 1'b1;
      end
      model_edge();
      tick();
      check_all("rnd", ref_p, ref_co);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1 slice, directly downstream of the M (multiplier) and C pipeline registers.
- Selects X and Z operands from M, D:A:B, C, PCIN and its own P feedback, then adds or subtracts with carry-in.
- Registers the 48-bit result as P with CARRYOUT.
- Drives PCOUT to the next slice.

Parameters:
- PREG, 1, 1 = register P and CARRYOUT; 0 = combinational outputs
- OPMODEREG, 1, 1 = opmode passes through an internal register; 0 = used directly
- CARRYINREG, 1, 1 = carry-in passes through an internal register; 0 = used directly
- WIDTH_P, 48, result/accumulator width; M width fixed at 36

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; clears all internal registers
- ce_p  input  1  clock enable for P and CARRYOUT registers
- ce_opmode  input  1  clock enable for opmode register
- ce_carryin  input  1  clock enable for carry-in register
- opmode  input  8  [1:0] X select, [3:2] Z select, [7] 0=add/1=subtract; bits [6:4] ignored here
- m  input  36  product from the M stage, unsigned
- dab  input  48  concatenation {D[11:0],A[17:0],B[17:0]}
- c  input  48  C operand from the C stage
- pcin  input  48  cascade input from the previous slice
- carryin  input  1  carry-in, already source-selected upstream
- p  output  48  result
- carryout  output  1  carry/borrow out of the post-adder
- carryoutf  output  1  copy of carryout for fabric
- pcout  output  48  equals p

Behaviour:
- Reset:
  - rst_n low at any time immediately clears P, carryout, opmode_r and cyi_r to 0, independent of clk.
  - With PREG=1, p/pcout/carryout/carryoutf read 0 while reset is held and on the first clk edge after release.
- Register capture:
  - opmode_r <= opmode when ce_opmode=1, else hold. The effective opmode is opmode_r if OPMODEREG=1, else opmode.
  - cyi_r <= carryin when ce_carryin=1, else hold. The effective carry-in is cyi_r if CARRYINREG=1, else carryin.
- X mux (opmode[1:0]):
  - 00 -> 0
  - 01 -> {12'b0, m}
  - 10 -> P register
  - 11 -> dab
- Z mux (opmode[3:2]):
  - 00 -> 0
  - 01 -> pcin
  - 10 -> P register
  - 11 -> c
- Arithmetic (49-bit, unsigned operands):
  - add: Z + X + cin
  - subtract: Z - (X + cin)
  - Result[47:0] -> P next; result[48] -> carryout next (borrow indicator on subtract).
  - Wrap modulo 2^48; no saturation, no overflow flag.
- Output timing:
  - PREG=1: P and carryout load on the rising edge when ce_p=1, else hold. Latency from operands (m, dab, c, pcin) to p is 1 cycle.
  - PREG=0: p and carryout follow the adder combinationally.
- Feedback: X=10 or Z=10 always uses the internal P register value.
  - With PREG=0 that register stays 0, so P feedback reads 0. This configuration is illegal for accumulation; no loop is formed.
- ce_p=0 with changing inputs: p, carryout hold; accumulator is frozen.
- Simultaneous ce_opmode and ce_p with OPMODEREG=1: the P update on that edge uses the old opmode_r. The new opmode applies from the next edge (one-cycle opmode lead is the upstream's responsibility).
- Reset asserted mid-accumulation: accumulator clears to 0; the first enabled edge after release computes from P=0.
- carryoutf is always equal to carryout. pcout is always equal to p.

Test Plan:
- Reset: drive operands non-zero, pulse rst_n low between edges -> p=0, carryout=0 immediately. Hold rst_n low across 3 edges -> outputs stay 0.
- Multiply-add, all regs=1: opmode=8'h0D (X=M, Z=C, add), m=36'h0_0000_0064, c=48'd1000, carryin=1. After 1 edge to load opmode_r/cyi_r and 1 edge to load P -> p=1101, carryout=0.
- Accumulate: opmode=8'h09 (X=M, Z=P), m=5, cin=0, ce_p=1 for 4 edges from p=0 -> p=5,10,15,20. Deassert ce_p one cycle -> p holds 20.
- Wrap/carry: opmode X=dab, Z=C, add, dab=48'hFFFF_FFFF_FFFF, c=1, cin=0 -> p=0, carryout=1, carryoutf=1.
- Subtract/borrow: opmode=8'h8F (X=dab, Z=C, subtract), c=10, dab=3, cin=1 -> p=6, carryout=0. Then dab=20 -> p=48'hFFFF_FFFF_FFF5, carryout=1.
- Cascade and opmode timing: Z=PCIN, X=0, pcin=48'h1234, with opmode change and ce_opmode on the same edge as ce_p -> p reflects old opmode on that edge and 48'h1234 on the next edge. pcout equals p throughout.
